// File: rtl/eth_pkg.sv
// Shared 64b/66b PCS constants used by the scrambler and descrambler.
package eth_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // x^58 + x^39 + 1 self-synchronous scrambler
    localparam int unsigned SCR_LEN        = 58;
    localparam logic [57:0] SCRAMBLER_INIT = '1;
    localparam int unsigned SCR_TAP_A      = 38;
    localparam int unsigned SCR_TAP_B      = 57;

    typedef enum logic {
        EXPECT_HDR,
        EXPECT_BODY
    } blk_state_t;

    function automatic logic hdr_is_legal(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_skid_buffer.sv
// Two-entry skid buffer: output register plus one skid register, registered ready.
module eth_skid_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_in_acc;
    logic w_out_free;
    logic w_skid_valid_nxt;

    assign w_in_acc   = i_valid && r_ready;
    assign w_out_free = !r_out_valid || i_ready;

    // Skid occupancy after this edge: drains whenever the output register frees up
    always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        if (w_out_free) begin
            w_skid_valid_nxt = 1'b0;
        end else if (w_in_acc) begin
            w_skid_valid_nxt = 1'b1;
        end
    end

    // Output/skid registers; ready is registered so it never depends on i_ready combinationally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_ready      <= !w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                end else begin
                    r_out_valid <= w_in_acc;
                    if (w_in_acc) begin
                        r_out_data <= i_data;
                    end
                end
            end else if (w_in_acc) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/eth_scrambler.sv
// 64b/66b payload scrambler (x^58+x^39+1) with block-sequence tracking and skid output.
module eth_scrambler
    import eth_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_scrambler_bypass,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_header,
    input  logic                  i_headervalid,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_header,
    output logic                  o_headervalid,
    output logic                  o_seq_error,
    output logic                  o_hdr_error
);

    localparam int unsigned WORDS_PER_BLOCK = 64 / DATA_WIDTH;
    localparam int unsigned CNT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int unsigned PW    = DATA_WIDTH + 3;

    logic [SCR_LEN-1:0]    r_scr;
    logic [SCR_LEN-1:0]    w_scr_nxt;
    logic [DATA_WIDTH-1:0] w_scr_data;
    logic [1:0]            r_last_hdr;
    logic [1:0]            w_hdr_in;
    blk_state_t            r_state;
    blk_state_t            w_state_nxt;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_seq_err;
    logic                  w_hdr_err;
    logic                  r_seq_error;
    logic                  r_hdr_error;
    logic                  w_ready;
    logic                  w_in_acc;
    logic [PW-1:0]         w_out_payload;

    assign w_in_acc = i_valid && w_ready;

    // Scramble MSB first; the state always shifts in the line bit, so bypass keeps it in sync
    always_comb begin : scramble_word
        logic [DATA_WIDTH-1:0] v_d;
        logic                  v_b;
        v_d        = i_data;
        v_b        = 1'b0;
        w_scr_nxt  = r_scr;
        w_scr_data = '0;
        for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
            v_b = v_d[DATA_WIDTH-1] ^
                  (i_scrambler_bypass ? 1'b0 : (w_scr_nxt[SCR_TAP_A] ^ w_scr_nxt[SCR_TAP_B]));
            w_scr_data = {w_scr_data[DATA_WIDTH-2:0], v_b};
            w_scr_nxt  = {w_scr_nxt[SCR_LEN-2:0], v_b};
            v_d        = v_d << 1;
        end
    end

    // Scrambler state advances only on accepted words
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scr <= SCRAMBLER_INIT;
        end else if (w_in_acc) begin
            r_scr <= w_scr_nxt;
        end
    end

    // Body words carry the most recent header forward so o_header only changes on header words
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_hdr <= 2'b00;
        end else if (w_in_acc && i_headervalid) begin
            r_last_hdr <= i_header;
        end
    end

    assign w_hdr_in = i_headervalid ? i_header : r_last_hdr;

    // Block-position state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= EXPECT_HDR;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next block position and sequence/header violation detection
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_seq_err   = 1'b0;
        w_hdr_err   = 1'b0;
        if (w_in_acc) begin
            w_hdr_err = i_headervalid && !hdr_is_legal(i_header);
            unique case (r_state)
                EXPECT_HDR: begin
                    if (i_headervalid) begin
                        if (WORDS_PER_BLOCK == 1) begin
                            w_count_nxt = '0;
                            w_state_nxt = EXPECT_HDR;
                        end else begin
                            w_count_nxt = CNT_W'(1);
                            w_state_nxt = EXPECT_BODY;
                        end
                    end else begin
                        w_seq_err = 1'b1;
                    end
                end
                EXPECT_BODY: begin
                    if (i_headervalid) begin
                        w_seq_err   = 1'b1;
                        w_count_nxt = CNT_W'(1);
                        w_state_nxt = EXPECT_BODY;
                    end else if (r_count == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                        w_count_nxt = '0;
                        w_state_nxt = EXPECT_HDR;
                    end else begin
                        w_count_nxt = r_count + CNT_W'(1);
                        w_state_nxt = EXPECT_BODY;
                    end
                end
                default: begin
                    w_count_nxt = '0;
                    w_state_nxt = EXPECT_HDR;
                end
            endcase
        end
    end

    // Error pulses land one cycle after acceptance, independent of output stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq_error <= 1'b0;
            r_hdr_error <= 1'b0;
        end else begin
            r_seq_error <= w_seq_err;
            r_hdr_error <= w_hdr_err;
        end
    end

    eth_skid_buffer #(
        .WIDTH(PW)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (w_ready),
        .i_data  ({w_scr_data, w_hdr_in, i_headervalid}),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (w_out_payload)
    );

    assign o_ready = w_ready;
    assign {o_data, o_header, o_headervalid} = w_out_payload;
    assign o_seq_error = r_seq_error;
    assign o_hdr_error = r_hdr_error;

endmodule

// File: tb/tb_eth_scrambler.sv
// Self-checking bench for eth_scrambler: bit-level line model plus loopback descrambler model.
module tb_eth_scrambler;

    localparam int DW  = 32;
    localparam int WPB = 64 / DW;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_scrambler_bypass;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic [1:0]    i_header;
    logic          i_headervalid;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [1:0]    o_header;
    logic          o_headervalid;
    logic          o_seq_error;
    logic          o_hdr_error;

    eth_scrambler #(.DATA_WIDTH(DW)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_scrambler_bypass (i_scrambler_bypass),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_data             (i_data),
        .i_header           (i_header),
        .i_headervalid      (i_headervalid),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_data             (o_data),
        .o_header           (o_header),
        .o_headervalid      (o_headervalid),
        .o_seq_error        (o_seq_error),
        .o_hdr_error        (o_hdr_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] line;
        logic [31:0] orig;
        logic [1:0]  hdr;
        logic        hv;
        logic        byp;
    } exp_t;

    exp_t        q[$];
    bit          tx_hist[$];
    bit          rx_hist[$];
    int          checks;
    int          failures;
    int          pos;
    int          dut_acc;
    logic [1:0]  last_hdr;
    logic        exp_seq;
    logic        exp_hdr;
    logic        stall_prev;
    logic [31:0] stall_data;
    logic [1:0]  stall_hdr;
    logic        stall_hv;
    logic        byp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        tx_hist.delete();
        rx_hist.delete();
        for (int k = 0; k < 58; k++) begin
            tx_hist.push_back(1'b1);
            rx_hist.push_back(1'b1);
        end
        q.delete();
        pos        = 0;
        last_hdr   = 2'b00;
        exp_seq    = 1'b0;
        exp_hdr    = 1'b0;
        stall_prev = 1'b0;
    endfunction

    // Line bit = data ^ (line bit 39 ago) ^ (line bit 58 ago), unless bypassed
    function automatic logic [31:0] scramble(input logic [31:0] d, input logic bp);
        logic [31:0] v_d;
        logic [31:0] r;
        bit          b;
        v_d = d;
        r   = '0;
        for (int k = 0; k < 32; k++) begin
            b = v_d[31];
            if (!bp) b = b ^ tx_hist[tx_hist.size() - 39] ^ tx_hist[tx_hist.size() - 58];
            r = {r[30:0], b};
            tx_hist.push_back(b);
            void'(tx_hist.pop_front());
            v_d = v_d << 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] descramble(input logic [31:0] l, input logic bp);
        logic [31:0] v_l;
        logic [31:0] r;
        bit          b;
        bit          d;
        v_l = l;
        r   = '0;
        for (int k = 0; k < 32; k++) begin
            b = v_l[31];
            d = bp ? b : (b ^ rx_hist[rx_hist.size() - 39] ^ rx_hist[rx_hist.size() - 58]);
            r = {r[30:0], d};
            rx_hist.push_back(b);
            void'(rx_hist.pop_front());
            v_l = v_l << 1;
        end
        return r;
    endfunction

    task automatic step(input logic v, input logic [31:0] d, input logic h,
                        input logic [1:0] hd, input logic rdy, input logic bp);
        exp_t        e;
        logic [31:0] dsc;
        logic        m_ready;
        logic        m_valid;
        @(negedge i_clk);
        chk("seq_error", o_seq_error, exp_seq);
        chk("hdr_error", o_hdr_error, exp_hdr);
        m_valid = (q.size() != 0);
        m_ready = (q.size() < 2);
        chk("o_valid", o_valid, m_valid);
        chk("o_ready", o_ready, m_ready);
        if (stall_prev) begin
            chk("stall_data", o_data, stall_data);
            chk("stall_hdr", o_header, stall_hdr);
            chk("stall_hv", o_headervalid, stall_hv);
        end
        i_valid            = v;
        i_data             = d;
        i_headervalid      = h;
        i_header           = hd;
        i_ready            = rdy;
        i_scrambler_bypass = bp;
        #1;
        if (i_valid && o_ready) dut_acc++;
        exp_seq = 1'b0;
        exp_hdr = 1'b0;
        if (m_valid && rdy) begin
            e = q.pop_front();
            chk("o_data", o_data, e.line);
            chk("o_header", o_header, e.hdr);
            chk("o_headervalid", o_headervalid, e.hv);
            dsc = descramble(o_data, e.byp);
            chk("loopback", dsc, e.orig);
        end
        stall_prev = m_valid && !rdy;
        stall_data = o_data;
        stall_hdr  = o_header;
        stall_hv   = o_headervalid;
        if (v && m_ready) begin
            e.orig = d;
            e.byp  = bp;
            e.hv   = h;
            e.hdr  = h ? hd : last_hdr;
            if (h) last_hdr = hd;
            exp_hdr = h && (hd == 2'b00 || hd == 2'b11);
            if (pos == 0) begin
                if (h) pos = 1 % WPB;
                else   exp_seq = 1'b1;
            end else begin
                if (h) begin
                    exp_seq = 1'b1;
                    pos     = 1;
                end else begin
                    pos = (pos + 1) % WPB;
                end
            end
            e.line = scramble(d, bp);
            q.push_back(e);
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        int          a0;
        logic        h;
        logic [1:0]  hd;
        checks = 0; failures = 0; dut_acc = 0;
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_header = 2'b00;
        i_headervalid = 1'b0; i_ready = 1'b0; i_scrambler_bypass = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_data", o_data, 0);
        chk("rst_header", o_header, 0);
        chk("rst_hv", o_headervalid, 0);
        chk("rst_seq", o_seq_error, 0);
        chk("rst_hdr", o_hdr_error, 0);
        i_rst_n = 1'b1;

        // First word after reset: zero data through an all-ones state scrambles to zero
        step(1'b1, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0);
        @(posedge i_clk); #1;
        chk("first_valid", o_valid, 1);
        chk("first_data", o_data, 32'h0);
        chk("first_hdr", o_header, 2'b01);
        step(1'b1, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        drain(2);

        // Known pattern, data and control headers
        step(1'b1, 32'hDEADBEEF, 1'b1, 2'b01, 1'b1, 1'b0);
        step(1'b1, 32'h01234567, 1'b0, 2'b00, 1'b1, 1'b0);
        step(1'b1, 32'hCAFEF00D, 1'b1, 2'b10, 1'b1, 1'b0);
        step(1'b1, 32'h89ABCDEF, 1'b0, 2'b00, 1'b1, 1'b0);
        drain(2);

        // Downstream stall with upstream always valid
        a0 = dut_acc;
        for (int k = 0; k < 5; k++) step(1'b1, $urandom, pos == 0, 2'b01, 1'b0, 1'b0);
        chk("stall_accepts", dut_acc - a0, 2);
        chk("stall_ready_low", o_ready, 0);
        drain(4);

        // Two headers in a row, then a correct body/header sequence must be clean
        step(1'b1, 32'h11111111, 1'b1, 2'b01, 1'b1, 1'b0);
        step(1'b1, 32'h22222222, 1'b1, 2'b01, 1'b1, 1'b0);
        step(1'b1, 32'h33333333, 1'b0, 2'b00, 1'b1, 1'b0);
        step(1'b1, 32'h44444444, 1'b1, 2'b10, 1'b1, 1'b0);
        step(1'b1, 32'h55555555, 1'b0, 2'b00, 1'b1, 1'b0);
        drain(2);

        // Illegal sync header
        step(1'b1, 32'h66666666, 1'b1, 2'b11, 1'b1, 1'b0);
        @(posedge i_clk); #1;
        chk("hdr11_pulse", o_hdr_error, 1);
        chk("hdr11_header", o_header, 2'b11);
        step(1'b1, 32'h77777777, 1'b0, 2'b00, 1'b1, 1'b0);
        drain(2);

        // Two bypassed blocks, then scrambling resumes
        for (int k = 0; k < 2 * WPB; k++) step(1'b1, $urandom, pos == 0, 2'b01, 1'b1, 1'b1);
        for (int k = 0; k < 2 * WPB; k++) step(1'b1, $urandom, pos == 0, 2'b10, 1'b1, 1'b0);
        drain(2);

        // Mid-operation reset drops buffered words
        step(1'b1, 32'hA5A5A5A5, 1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 32'h5A5A5A5A, 1'b0, 2'b00, 1'b0, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", o_ready, 0);
        chk("midrst_data", o_data, 0);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        drain(2);

        // Randomised traffic with occasional sequence/header faults and bypass toggles
        byp = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) byp = ~byp;
            h = (pos == 0);
            if ($urandom_range(0, 9) == 0) h = ~h;
            case ($urandom_range(0, 9))
                0:       hd = 2'b00;
                1:       hd = 2'b11;
                2, 3, 4: hd = 2'b10;
                default: hd = 2'b01;
            endcase
            step($urandom_range(0, 3) != 0, $urandom, h, hd, $urandom_range(0, 3) != 0, byp);
        end
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
